inst_cache_dm: RTL and testbench

Parametrised direct-mapped instruction cache with multi-word lines, per-line valid bits, a line-refill state machine and a synchronous invalidate. It sits between the CPU fetch stage and the instruction-side bus interface. It replaces the one-word-per-entry lookup with a burst line refill driven by a request/acknowledge handshake. Fetch stalls are reported through pc_wait_stop_choke.

---
 rtl/inst_cache_dm_if.sv | 29 ++
 rtl/inst_cache_dm.sv | 129 ++++++++++++
 tb/tb_inst_cache_dm.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_dm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_cache_dm_if : fetch-side and refill-bus signals of inst_cache_dm |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface inst_cache_dm_if;
   logic [31:0] PC;
   logic        pc_valid;
   logic [31:0] instruction;
   logic        pc_wait_stop_choke;
   logic        inst_addr_err;
   logic        invalidate;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;

   modport slave (
      input  PC, pc_valid, invalidate, mem_ack, mem_rdata, mem_rvalid,
      output instruction, pc_wait_stop_choke, inst_addr_err, mem_req, mem_addr
   );

   modport master (
      output PC, pc_valid, invalidate, mem_ack, mem_rdata, mem_rvalid,
      input  instruction, pc_wait_stop_choke, inst_addr_err, mem_req, mem_addr
   );
endinterface
`default_nettype wire

// File: rtl/inst_cache_dm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_cache_dm : direct-mapped I-cache, zero-latency hit, burst refill |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module inst_cache_dm #(
   parameter int unsigned INDEX_BITS  = 6,
   parameter int unsigned OFFSET_BITS = 2,
   parameter int unsigned TAG_BITS    = 30 - INDEX_BITS - OFFSET_BITS
) (
   input  logic           clk,
   input  logic           reset,
   inst_cache_dm_if.slave bus_io
);
   localparam int unsigned c_LINES   = 1 << INDEX_BITS;
   localparam int unsigned c_WORDS   = 1 << OFFSET_BITS;
   localparam int unsigned c_TAG_LSB = 2 + INDEX_BITS + OFFSET_BITS;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_REFILL = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [c_LINES-1:0]     valid_q, valid_d;
   logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
   logic                   poison_q, poison_d;
   logic [TAG_BITS-1:0]    tag_arr_q  [c_LINES];
   logic [31:0]            data_arr_q [c_LINES][c_WORDS];

   logic [TAG_BITS-1:0]    w_tag;
   logic [INDEX_BITS-1:0]  w_index;
   logic [OFFSET_BITS-1:0] w_offset;
   logic                   w_aligned, w_hit, w_wr_en, w_last;
   logic [31:0]            w_rd_word, w_instr;
   logic                   w_stall, w_req;

   assign w_tag     = bus_io.PC[31:c_TAG_LSB];
   assign w_index   = bus_io.PC[c_TAG_LSB-1:2+OFFSET_BITS];
   assign w_offset  = bus_io.PC[2+OFFSET_BITS-1:2];
   assign w_aligned = (bus_io.PC[1:0] == 2'b00);
   assign w_hit     = bus_io.pc_valid & w_aligned & valid_q[w_index] &
                      (tag_arr_q[w_index] == w_tag);
   assign w_rd_word = data_arr_q[w_index][w_offset];
   assign w_wr_en   = (state_q == ST_REFILL) & bus_io.mem_rvalid;
   assign w_last    = w_wr_en & (&cnt_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      poison_d = poison_q;
      valid_d  = bus_io.invalidate ? '0 : valid_q;
      w_instr  = 32'd0;
      w_stall  = 1'b0;
      w_req    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_hit) begin
               w_instr = w_rd_word;
            end else if (bus_io.pc_valid && w_aligned) begin
               w_stall  = 1'b1;
               poison_d = 1'b0;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            w_req    = 1'b1;
            w_stall  = 1'b1;
            poison_d = poison_q | bus_io.invalidate;
            if (bus_io.mem_ack) begin
               cnt_d   = '0;
               state_d = ST_REFILL;
            end
         end
         ST_REFILL: begin
            w_stall  = 1'b1;
            poison_d = poison_q | bus_io.invalidate;
            if (w_wr_en) begin
               cnt_d = cnt_q + 1'b1;
            end
            // An invalidate seen at any point of the refill leaves the line invalid.
            if (w_last) begin
               state_d = ST_DONE;
               if (!poison_q && !bus_io.invalidate) begin
                  valid_d[w_index] = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_instr = w_rd_word;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         valid_q  <= '0;
         cnt_q    <= '0;
         poison_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         poison_q <= poison_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_wr_en) begin
         data_arr_q[w_index][cnt_q] <= bus_io.mem_rdata;
      end
      if (!reset && w_last) begin
         tag_arr_q[w_index] <= w_tag;
      end
   end

   // Outputs are forced quiet for the whole reset cycle, not just after it.
   assign bus_io.instruction        = reset ? 32'd0 : w_instr;
   assign bus_io.pc_wait_stop_choke = ~reset & w_stall;
   assign bus_io.mem_req            = ~reset & w_req;
   assign bus_io.inst_addr_err      = ~reset & bus_io.pc_valid & ~w_aligned;
   assign bus_io.mem_addr           = {bus_io.PC[31:2+OFFSET_BITS], {(2+OFFSET_BITS){1'b0}}};
endmodule
`default_nettype wire

// File: tb/tb_inst_cache_dm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_cache_dm : directed self-checking bench for inst_cache_dm     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_inst_cache_dm;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   inst_cache_dm_if bus ();

   inst_cache_dm #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // PC and pc_valid must be held across any cycle that reported a stall.
   logic        r_prev_stall;
   logic [31:0] r_prev_pc;
   always @(posedge clk) begin
      if (r_prev_stall && bus.pc_valid && !reset) chk("pc_held", bus.PC, r_prev_pc);
      r_prev_stall <= bus.pc_wait_stop_choke;
      r_prev_pc    <= bus.PC;
   end

   task automatic fetch_hit(input string tag, input logic [31:0] pc, input logic [31:0] exp,
                            input logic inv);
      @(negedge clk);
      bus.PC = pc; bus.pc_valid = 1'b1; bus.invalidate = inv;
      #1;
      chk({tag, "_instr"}, bus.instruction, exp);
      chk({tag, "_stall"}, {31'd0, bus.pc_wait_stop_choke}, 32'd0);
      chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd0);
      @(negedge clk);
      bus.invalidate = 1'b0; bus.pc_valid = 1'b0;
   endtask

   task automatic miss_fill(input string tag, input logic [31:0] pc, input logic [31:0] exp_addr,
                            input int ack_wait, input logic [31:0] base, input logic [15:0] pat,
                            input int plen, input int inv_beat, input logic [31:0] exp_word,
                            input int exp_stalls);
      int stalls, beats, step;
      stalls = 0;
      @(negedge clk);
      bus.PC = pc; bus.pc_valid = 1'b1;
      #1;
      chk({tag, "_miss_stall"}, {31'd0, bus.pc_wait_stop_choke}, 32'd1);
      chk({tag, "_idle_req"}, {31'd0, bus.mem_req}, 32'd0);
      stalls += int'(bus.pc_wait_stop_choke);
      for (int i = 0; i <= ack_wait; i++) begin
         @(negedge clk);
         bus.mem_ack = (i == ack_wait);
         #1;
         chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
         if (i == 0) chk({tag, "_addr"}, bus.mem_addr, exp_addr);
         stalls += int'(bus.pc_wait_stop_choke);
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      beats = 0; step = 0;
      while (beats < 4) begin
         bus.mem_rvalid = (step < plen) ? pat[step] : 1'b1;
         bus.mem_rdata  = base + beats;
         bus.invalidate = bus.mem_rvalid && (beats == inv_beat);
         #1;
         if (step == 0) chk({tag, "_refill_req"}, {31'd0, bus.mem_req}, 32'd0);
         stalls += int'(bus.pc_wait_stop_choke);
         if (bus.mem_rvalid) beats++;
         step++;
         @(negedge clk);
      end
      bus.mem_rvalid = 1'b0; bus.invalidate = 1'b0; bus.mem_rdata = 32'd0;
      #1;
      chk({tag, "_done_stall"}, {31'd0, bus.pc_wait_stop_choke}, 32'd0);
      chk({tag, "_done_instr"}, bus.instruction, exp_word);
      chk({tag, "_stall_cycles"}, stalls, exp_stalls);
      bus.pc_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0;
      r_prev_stall = 1'b0; r_prev_pc = 32'd0;
      reset = 1'b1;
      bus.PC = 32'd0; bus.pc_valid = 1'b0; bus.invalidate = 1'b0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0; bus.mem_rvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_instr", bus.instruction, 32'd0);
      chk("rst_stall", {31'd0, bus.pc_wait_stop_choke}, 32'd0);
      chk("rst_err", {31'd0, bus.inst_addr_err}, 32'd0);
      chk("rst_req", {31'd0, bus.mem_req}, 32'd0);

      // Cold miss: ack on the third REQ cycle, four back-to-back beats.
      miss_fill("cold", 32'h0000_1004, 32'h0000_1000, 2, 32'hA0, 16'h000F, 4, -1, 32'hA1, 8);
      fetch_hit("hit8", 32'h0000_1008, 32'hA2, 1'b0);
      fetch_hit("hitC", 32'h0000_100C, 32'hA3, 1'b0);
      fetch_hit("hit0", 32'h0000_1000, 32'hA0, 1'b0);

      // Misaligned fetch: error flag only, no refill started.
      @(negedge clk);
      bus.PC = 32'h0000_1002; bus.pc_valid = 1'b1;
      #1;
      chk("mis_err", {31'd0, bus.inst_addr_err}, 32'd1);
      chk("mis_stall", {31'd0, bus.pc_wait_stop_choke}, 32'd0);
      chk("mis_instr", bus.instruction, 32'd0);
      chk("mis_req", {31'd0, bus.mem_req}, 32'd0);
      @(negedge clk);
      bus.pc_valid = 1'b0;
      #1;
      chk("mis_noreq", {31'd0, bus.mem_req}, 32'd0);

      // Conflict on index 0, then gapped refill 1,0,0,1,1,0,1.
      miss_fill("conf", 32'h0000_2000, 32'h0000_2000, 1, 32'hB0, 16'h000F, 4, -1, 32'hB0, 7);
      fetch_hit("hitB1", 32'h0000_2004, 32'hB1, 1'b0);
      miss_fill("gap", 32'h0000_1000, 32'h0000_1000, 0, 32'hD0, 16'h0059, 7, -1, 32'hD0, 9);
      fetch_hit("gapD1", 32'h0000_1004, 32'hD1, 1'b0);
      fetch_hit("gapD2", 32'h0000_1008, 32'hD2, 1'b0);
      fetch_hit("gapD3", 32'h0000_100C, 32'hD3, 1'b0);

      // Invalidate on the 2nd beat: word returned once, line stays invalid.
      miss_fill("inv", 32'h0000_4014, 32'h0000_4010, 0, 32'hC0, 16'h000F, 4, 1, 32'hC1, 6);
      miss_fill("inv_re", 32'h0000_4014, 32'h0000_4010, 0, 32'hE0, 16'h000F, 4, -1, 32'hE1, 6);
      // Invalidate in IDLE still serves the old hit, then the line misses.
      fetch_hit("idle_inv", 32'h0000_4014, 32'hE1, 1'b1);
      // Invalidate coincident with the last beat.
      miss_fill("inv_last", 32'h0000_4014, 32'h0000_4010, 0, 32'h50, 16'h000F, 4, 3, 32'h51, 6);
      miss_fill("inv_last_re", 32'h0000_4014, 32'h0000_4010, 0, 32'h60, 16'h000F, 4, -1, 32'h61, 6);
      fetch_hit("hit61", 32'h0000_4014, 32'h61, 1'b0);
      miss_fill("inv_other", 32'h0000_1008, 32'h0000_1000, 0, 32'h80, 16'h000F, 4, -1, 32'h82, 6);

      // Reset while in REFILL after two beats.
      @(negedge clk);
      bus.PC = 32'h0000_3000; bus.pc_valid = 1'b1;
      #1;
      chk("rr_miss", {31'd0, bus.pc_wait_stop_choke}, 32'd1);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      #1;
      chk("rr_req", {31'd0, bus.mem_req}, 32'd1);
      @(negedge clk);
      bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hF0;
      @(negedge clk);
      bus.mem_rdata = 32'hF1;
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.pc_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rr_req_after", {31'd0, bus.mem_req}, 32'd0);
      chk("rr_stall_after", {31'd0, bus.pc_wait_stop_choke}, 32'd0);
      chk("rr_instr_after", bus.instruction, 32'd0);
      miss_fill("rr_re", 32'h0000_3000, 32'h0000_3000, 0, 32'h30, 16'h000F, 4, -1, 32'h30, 6);
      miss_fill("rr_old", 32'h0000_1008, 32'h0000_1000, 0, 32'h70, 16'h000F, 4, -1, 32'h72, 6);
      fetch_hit("hit73", 32'h0000_100C, 32'h73, 1'b0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
